// File: rtl/rv_muldiv_unit_if.sv
// rv_muldiv_unit_if
//   Request/response bundle between the execute stage and rv_muldiv_unit.
//   The request channel uses in_valid/in_ready and the result channel uses
//   out_valid/out_ready. On both channels a transfer happens on a rising clock
//   edge where valid and ready are both high. A producer holds valid and its
//   payload steady until that edge. A consumer may raise or drop ready at any
//   time. flush is a side-band kill, and it takes priority over both channels.
//
//   Signals:
//     flush      core -> unit  kill any in-flight operation
//     in_valid   core -> unit  request present (op, a, b valid)
//     in_ready   unit -> core  unit idle and able to accept
//     op         core -> unit  RV32M/RV64M funct3
//     a, b       core -> unit  rs1 / rs2 operands
//     out_valid  unit -> core  result present on out
//     out_ready  core -> unit  core takes the result
//     out        unit -> core  result
//     busy       unit -> core  unit is not idle
//     state_dbg  unit -> core  raw FSM state (0 IDLE, 1 CALC, 2 DONE)
interface rv_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out;
    logic            busy;
    logic [1:0]      state_dbg;

    modport master (
        output flush, in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, out, busy, state_dbg
    );

    modport slave (
        input  flush, in_valid, op, a, b, out_ready,
        output in_ready, out_valid, out, busy, state_dbg
    );
endinterface

// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit
//   Iterative RV32M/RV64M multiply/divide unit. It computes one result bit per
//   cycle. Multiplication uses a shift-add multiplier and division uses a
//   restoring divider. Both run on unsigned magnitudes, and the sign is
//   applied on the last iteration.
//   The normal latency is XLEN+1 cycles, counted from the accept cycle to the
//   first cycle with out_valid high.
//
//   Optional build macro MULDIV_EARLY_OUT_EN: when it is defined, these ops go
//   straight from IDLE to DONE with one cycle of latency:
//     - divide by zero
//     - signed divide overflow
//     - multiply by zero
//   Results are the same in both builds.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    rv_muldiv_unit_if.slave (request, result, flush, status)
//
//   Parameters:
//     XLEN   operand width, 32 or 64
//     CNT_W  iteration counter width (derived, do not override)
module rv_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input logic             clk,
    input logic             rst_n,
    rv_muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);

    state_t state_q, state_d;

    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q;       // original rs1, for REM/REMU by zero
    logic [XLEN-1:0]   opb_q;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc_q;     // product, or remainder:dividend/quotient
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_q;
    logic              div0_q;
    logic              ovf_q;
    logic [XLEN-1:0]   res_q;

    // Request decode. MULH signs both operands and MULHSU signs only a.
    // DIV/REM sign both operands. MUL is the same signed or unsigned, so it is
    // treated as unsigned.
    logic            accept, last, early_hit;
    logic            a_signed_in, b_signed_in, a_neg_in, b_neg_in;
    logic            neg_in, div0_in, ovf_in;
    logic [XLEN-1:0] a_mag_in, b_mag_in;

    assign accept      = (state_q == IDLE) & bus.in_valid & ~bus.flush;
    assign last        = (state_q == CALC) & (cnt_q == CNT_W'(1));
    assign a_signed_in = bus.op[2] ? ~bus.op[0]
                                   : ((bus.op[1:0] == 2'b01) | (bus.op[1:0] == 2'b10));
    assign b_signed_in = bus.op[2] ? ~bus.op[0] : (bus.op[1:0] == 2'b01);
    assign a_neg_in    = a_signed_in & bus.a[XLEN-1];
    assign b_neg_in    = b_signed_in & bus.b[XLEN-1];
    assign a_mag_in    = a_neg_in ? -bus.a : bus.a;
    assign b_mag_in    = b_neg_in ? -bus.b : bus.b;
    // The remainder takes the sign of the dividend. All other ops take the
    // xor of the operand signs.
    assign neg_in      = (bus.op[2] & bus.op[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);
    assign div0_in     = (bus.b == '0);
    assign ovf_in      = bus.op[2] & ~bus.op[0] & (bus.a == MIN_VAL) & (&bus.b);

`ifdef MULDIV_EARLY_OUT_EN
    logic [XLEN-1:0] early_res;
    assign early_hit = bus.op[2] ? (div0_in | ovf_in)
                                 : ((bus.a == '0) | (bus.b == '0));
    always_comb begin
        early_res = '0;
        if (bus.op[2]) begin
            if (div0_in)     early_res = bus.op[1] ? bus.a : '1;
            else if (ovf_in) early_res = bus.op[1] ? '0 : MIN_VAL;
        end
    end
`else
    assign early_hit = 1'b0;
`endif

    // One iteration of each engine.
    // The multiplier adds the multiplicand into the upper half when the low
    // bit is set, then shifts the whole register right.
    // The divider shifts remainder:dividend left by one. Its compare needs
    // XLEN+1 bits because the shifted remainder can reach 2*divisor-1.
    logic [XLEN:0]     mul_sum, div_rem;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] mul_next, div_next, acc_next, prod_fix;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
    assign div_rem  = acc_q[2*XLEN-1:XLEN-1];
    assign div_ge   = (div_rem >= {1'b0, opb_q});
    assign div_diff = div_rem[XLEN-1:0] - opb_q;
    assign div_next = {(div_ge ? div_diff : div_rem[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    assign acc_next = op_q[2] ? div_next : mul_next;
    assign prod_fix = neg_q ? -acc_next : acc_next;

    logic [XLEN-1:0] quo, rem, final_res;
    assign quo = acc_next[XLEN-1:0];
    assign rem = acc_next[2*XLEN-1:XLEN];

    always_comb begin
        final_res = '0;
        if (!op_q[2])
            final_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        else if (op_q[1])
            final_res = div0_q ? a_q : (ovf_q ? '0 : (neg_q ? -rem : rem));
        else
            final_res = div0_q ? '1 : (ovf_q ? MIN_VAL : (neg_q ? -quo : quo));
    end

    // Control FSM. flush has the highest priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (accept) state_d = early_hit ? DONE : CALC;
                CALC:    if (last) state_d = DONE;
                DONE:    if (bus.out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            a_q    <= '0;
            opb_q  <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            neg_q  <= 1'b0;
            div0_q <= 1'b0;
            ovf_q  <= 1'b0;
            res_q  <= '0;
        end else if (accept) begin
            op_q   <= bus.op;
            a_q    <= bus.a;
            opb_q  <= b_mag_in;
            acc_q  <= {{XLEN{1'b0}}, a_mag_in};
            cnt_q  <= CNT_LOAD;
            neg_q  <= neg_in;
            div0_q <= div0_in;
            ovf_q  <= ovf_in;
`ifdef MULDIV_EARLY_OUT_EN
            if (early_hit) res_q <= early_res;
`endif
        end else if (state_q == CALC) begin
            acc_q <= acc_next;
            cnt_q <= cnt_q - CNT_W'(1);
            if (last) res_q <= final_res;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out       = res_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_rv_muldiv_unit.sv
// tb_rv_muldiv_unit
//   Directed and random bench for rv_muldiv_unit at XLEN=32. Expected results
//   come either from constants or from a reference model written with 64-bit
//   integer arithmetic. They are queued in exp_q when an op is issued and are
//   popped when the result handshake completes.
module tb_rv_muldiv_unit;
    localparam int XLEN = 32;
    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
    localparam logic [31:0] MINV = 32'h8000_0000;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    rv_muldiv_unit_if #(.XLEN(XLEN)) bus ();
    rv_muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks   = 0;
    int failures = 0;
    logic [XLEN-1:0] exp_q[$];
    int              lat_q[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // reference model
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, ub, p;
        longint unsigned pu;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        pu = {32'h0, a} * {32'h0, b};
        r  = '0;
        case (op)
            MUL:    begin p = sa * sb; r = p[31:0];  end
            MULH:   begin p = sa * sb; r = p[63:32]; end
            MULHSU: begin p = sa * ub; r = p[63:32]; end
            MULHU:  r = pu[63:32];
            DIV: begin
                if (b == 0) r = '1;
                else if (a == MINV && b == '1) r = MINV;
                else begin p = sa / sb; r = p[31:0]; end
            end
            DIVU:   r = (b == 0) ? '1 : a / b;
            REM: begin
                if (b == 0) r = a;
                else if (a == MINV && b == '1) r = '0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        bit early = 0;
        bit special;
`ifdef MULDIV_EARLY_OUT_EN
        early = 1;
`endif
        special = op[2] ? ((b == 0) || (!op[0] && a == MINV && b == '1))
                        : (a == 0 || b == 0);
        return (early && special) ? 1 : XLEN + 1;
    endfunction

    // driver tasks
    // Present a request and return just after the accepting edge, which
    // starts cycle 1 of the op.
    task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 100) begin @(negedge clk); guard++; end
        bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        exp_q.push_back(exp);
        lat_q.push_back(exp_latency(op, a, b));
        start(op, a, b);
    endtask

    // Wait for the result while driving ignored garbage requests. Hold off
    // out_ready for `hold` cycles, then handshake.
    task automatic collect(input int hold, input string tag);
        int lat = 1;
        logic [31:0] exp;
        int exp_lat;
        exp     = exp_q.pop_front();
        exp_lat = lat_q.pop_front();
        bus.in_valid = 1'b1; bus.a = $urandom; bus.b = $urandom;
        @(negedge clk);
        while (!bus.out_valid && lat < 200) begin @(negedge clk); lat++; end
        bus.in_valid = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " out"}, bus.out, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold valid"}, {31'b0, bus.out_valid}, 32'd1);
            check({tag, " hold out"}, bus.out, exp);
            check({tag, " hold in_ready"}, {31'b0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        check({tag, " post in_ready"}, {31'b0, bus.in_ready}, 32'd1);
        check({tag, " post valid"}, {31'b0, bus.out_valid}, 32'd0);
    endtask

    // stimulus
    initial begin
        int seen;
        int guard;
        logic [2:0] op;
        logic [31:0] a, b;

        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.op = '0;
        bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("reset busy", {31'b0, bus.busy}, 32'd0);
        check("reset out", bus.out, 32'd0);
        rst_n = 1'b1;

        // directed multiply and divide
        issue(MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);    collect(0, "mul");
        issue(MULH, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF);   collect(0, "mulh");
        issue(MULHU, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006);  collect(0, "mulhu");
        issue(DIV, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD);    collect(0, "div");
        issue(REM, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFE);    collect(0, "rem");
        issue(DIVU, 32'h8000_0000, 32'd2, 32'h4000_0000);   collect(0, "divu");
        issue(DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);           collect(0, "divu0");
        issue(REMU, 32'd5, 32'd0, 32'd5);                   collect(0, "remu0");
        issue(DIV, MINV, 32'hFFFF_FFFF, MINV);              collect(0, "div ovf");
        issue(REM, MINV, 32'hFFFF_FFFF, 32'd0);             collect(0, "rem ovf");
        issue(DIV, 32'd9, 32'd0, 32'hFFFF_FFFF);            collect(0, "div0");
        issue(MUL, 32'd0, 32'd123, 32'd0);                  collect(0, "mul zero");

        // backpressure, then a second op
        issue(MULHSU, 32'h1234_5678, 32'h9ABC_DEF0, model(MULHSU, 32'h1234_5678, 32'h9ABC_DEF0));
        collect(10, "backpressure");
        issue(REMU, 32'd1000, 32'd7, 32'd6);                collect(0, "after bp");

        // flush at CALC iteration 10
        start(MUL, 32'd11, 32'd13);
        repeat (9) @(posedge clk);
        #2 bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        check("flush busy", {31'b0, bus.busy}, 32'd0);
        check("flush in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("flush out_valid", {31'b0, bus.out_valid}, 32'd0);
        seen = 0;
        repeat (40) begin @(negedge clk); if (bus.out_valid) seen++; end
        check("flush no pulse", 32'(seen), 32'd0);
        issue(MULHSU, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF); collect(0, "mulhsu post flush");

        // flush wins over a simultaneous accept
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = DIVU; bus.a = 32'd50; bus.b = 32'd5; bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0; bus.flush = 1'b0;
        check("flush vs accept busy", {31'b0, bus.busy}, 32'd0);

        // flush wins over the result handshake
        start(DIVU, 32'd100, 32'd7);
        guard = 0;
        @(negedge clk);
        while (!bus.out_valid && guard < 200) begin @(negedge clk); guard++; end
        check("flush done out", bus.out, 32'd14);
        bus.flush = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0; bus.out_ready = 1'b0;
        check("flush done valid", {31'b0, bus.out_valid}, 32'd0);
        check("flush done in_ready", {31'b0, bus.in_ready}, 32'd1);

        // asynchronous reset mid-op, sampled between clock edges
        start(DIV, 32'd12345, 32'd17);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async rst busy", {31'b0, bus.busy}, 32'd0);
        check("async rst in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("async rst out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("async rst out", bus.out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // random ops with special-case operands mixed in
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = MINV; b = '1; end
                2: a = '0;
                3: begin a = $urandom_range(0, 100); b = $urandom_range(1, 20); end
                4: a = {1'b1, a[30:0]};
                default: ;
            endcase
            issue(op, a, b, model(op, a, b));
            collect($urandom_range(0, 3), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rv_muldiv_unit.md
Name: rv_muldiv_unit

Overview:
- Iterative multiply/divide unit implementing the RV32M/RV64M integer ops. Parametrised in operand width.
- Sits beside the single-cycle ALU in the execute stage. The core stalls on in_ready/out_valid.
- Produces one result bit per cycle, using a shift-add multiplier and a restoring divider.
- Supports flush so an in-flight operation can be killed on a branch mispredict or trap.

Parameters:
XLEN, 32, operand/result width in bits; legal values 32 or 64.
CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
clk  input  1  core clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  abort any in-flight op, return to IDLE next cycle
in_valid  input  1  operation request
in_ready  output  1  unit can accept a request (high only in IDLE)
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  input  XLEN  rs1 operand
b  input  XLEN  rs2 operand
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out  output  XLEN  result
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; busy=0; out=0; internal registers cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch op/a/b.
  - Compute magnitudes: signed operands are negated if negative. MULH signs both operands, MULHSU signs only a, DIV/REM sign both.
  - Record result sign. For DIV this is sign(a)^sign(b); for REM it is sign(a).
  - Load counter=XLEN and go to CALC.
- CALC, one iteration per cycle, counter decrements:
  - Multiply: 2*XLEN product register; if multiplier LSB is set, add multiplicand to the upper half, then shift right 1.
  - Divide: shift the remainder:dividend pair left 1; if remainder >= divisor, subtract and set quotient LSB.
  - When counter reaches 1, this iteration is the last: apply sign correction (two's complement negate when the sign flag is set), select the result, go to DONE.
  - Result select: MUL = low XLEN of the product; MULH/MULHSU/MULHU = high XLEN; DIV/DIVU = quotient; REM/REMU = remainder.
- DONE:
  - out_valid=1 and out is held stable until out_ready.
  - On out_valid&&out_ready go to IDLE. in_ready rises that same next cycle, so no back-to-back accept in the handshake cycle.
- Latency: out_valid rises exactly XLEN+1 cycles after the accept edge (33 for XLEN=32).
- Special cases, computed to RISC-V spec, with the result forced at end of CALC:
  - Divide by zero (b=0): DIV/DIVU quotient = all ones; REM/REMU = a.
  - Signed overflow (a=MIN, b=-1): DIV = MIN; REM = 0.
  - No exceptions are raised.
- Flush:
  - In any state, flush=1 at a clock edge forces IDLE and out_valid=0 next cycle.
  - Flush wins over a simultaneous accept or out handshake. The flushed result is never presented.
- in_valid outside IDLE is ignored; operands are not re-sampled.
- rst_n low mid-CALC returns to reset values immediately, without waiting for a clock edge.
- All arithmetic is unsigned on internal magnitudes; sign is applied only at the end.
- Outputs are registered; no combinational path from inputs to out.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: in IDLE, on accept, the following skip CALC and go directly to DONE with the correct result:
  - divide by zero;
  - signed overflow;
  - multiply with either operand 0, giving result 0.
  - Latency for these cases is 1 cycle (out_valid on the cycle after accept).
- Undefined: every op takes the full XLEN+1 cycles; results are identical in both builds.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD), XLEN=32 -> out=0xFFFFFFEB, out_valid exactly 33 cycles after accept; MULH same operands -> 0xFFFFFFFF; MULHU -> 0x00000006.
- DIV a=-20, b=6 -> 0xFFFFFFFD (-3); REM same -> 0xFFFFFFFE (-2); DIVU a=0x80000000, b=2 -> 0x40000000.
- DIVU a=5, b=0 -> 0xFFFFFFFF; REMU -> 5; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM -> 0.
- With MULDIV_EARLY_OUT_EN, DIV by 0 -> out_valid 1 cycle after accept; MUL a=0, b=123 -> 0 in 1 cycle.
- Backpressure:
  - Hold out_ready=0 for 10 cycles -> out_valid and out stay stable, in_ready=0.
  - Release -> in_ready=1 next cycle.
  - A second op issued then completes correctly.
- Flush/reset:
  - Assert flush at CALC iteration 10 -> next cycle busy=0, in_ready=1, no out_valid pulse; a new MULHSU a=-2, b=3 -> 0xFFFFFFFF.
  - Pull rst_n low asynchronously mid-op -> outputs reset immediately.
